// File: rtl/npc_pkg.sv
// Shared constants and redirect-select encodings for the next-PC unit.
package npc_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int          IM_WORDS_DEF = 1024;
  localparam logic [31:0] WORD_BYTES   = 32'd4;

  typedef enum logic [2:0] {
    BR_SEQ  = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGT  = 3'b100,
    BR_J    = 3'b101,
    BR_JR   = 3'b110,
    BR_RSVD = 3'b111
  } br_op_e;
endpackage

// File: rtl/npc_target_calc.sv
// Combinational taken/target evaluation for the current instruction.
module npc_target_calc
  import npc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  br_op,
  input  logic        zero,
  input  logic        smaller,
  input  logic        greater,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] pc_plus4
);
  logic [31:0] br_tgt;

  assign pc_plus4 = pc + WORD_BYTES;
  assign br_tgt   = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = pc_plus4;
    case (br_op_e'(br_op))
      BR_BEQ: begin taken = zero;    target = br_tgt; end
      BR_BNE: begin taken = !zero;   target = br_tgt; end
      BR_BLT: begin taken = smaller; target = br_tgt; end
      BR_BGT: begin taken = greater; target = br_tgt; end
      BR_J:   begin taken = 1'b1;    target = {pc_plus4[31:28], imm26, 2'b00}; end
      BR_JR:  begin taken = 1'b1;    target = ra; end
      default: ;
    endcase
  end
endmodule

// File: rtl/npc_unit.sv
// Next-PC register unit with window/alignment fault halt.
// Optional branch delay slot via macro NPC_DELAY_SLOT_EN.
module npc_unit
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_WORDS = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  br_op,
  input  logic        zero,
  input  logic        smaller,
  input  logic        greater,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic [31:0] pc,
  output logic [31:0] link,
  output logic        redirected,
  output logic        halt
);
  // 33-bit window bounds so a window ending at 2^32 still compares correctly
  localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(IM_WORDS) * 33'(WORD_BYTES);

  logic        taken;
  logic [31:0] target, pc_plus4, nxt_pc;
  logic        nxt_redir, fault;

  npc_target_calc u_calc (
    .pc(pc), .br_op(br_op), .zero(zero), .smaller(smaller), .greater(greater),
    .imm16(imm16), .imm26(imm26), .ra(ra),
    .taken(taken), .target(target), .pc_plus4(pc_plus4)
  );

`ifdef NPC_DELAY_SLOT_EN
  logic        pend_vld;
  logic [31:0] pend_pc;

  // A pending target always wins over anything decoded in the delay slot
  always_comb begin
    nxt_pc    = pc_plus4;
    nxt_redir = 1'b0;
    if (pend_vld) begin
      nxt_pc    = pend_pc;
      nxt_redir = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend_pc  <= '0;
    end else if (en && !halt && !fault) begin
      pend_vld <= !pend_vld && taken;
      pend_pc  <= target;
    end
  end

  assign link = pc + 2 * WORD_BYTES;
`else
  always_comb begin
    nxt_pc    = taken ? target : pc_plus4;
    nxt_redir = taken;
  end

  assign link = pc + WORD_BYTES;
`endif

  assign fault = (nxt_pc[1:0] != 2'b00) || ({1'b0, nxt_pc} < WIN_LO) ||
                 ({1'b0, nxt_pc} >= WIN_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      redirected <= 1'b0;
      halt       <= 1'b0;
    end else if (en && !halt) begin
      if (fault) begin
        halt       <= 1'b1;
        redirected <= 1'b0;
      end else begin
        pc         <= nxt_pc;
        redirected <= nxt_redir;
      end
    end
  end
endmodule

// File: tb/tb_npc_unit.sv
// Directed self-checking bench for npc_unit; covers both NPC_DELAY_SLOT_EN builds.
module tb_npc_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0, en = 1'b0;
  logic [2:0]  br_op = 3'b000;
  logic        zero = 1'b0, smaller = 1'b0, greater = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] imm26 = '0;
  logic [31:0] ra = '0;
  logic [31:0] pc, link;
  logic        redirected, halt;
  int          n_chk = 0, n_fail = 0;

`ifdef NPC_DELAY_SLOT_EN
  localparam logic [31:0] LOFF = 32'd8;
`else
  localparam logic [31:0] LOFF = 32'd4;
`endif

  npc_unit dut (
    .clk(clk), .reset(reset), .en(en), .br_op(br_op), .zero(zero),
    .smaller(smaller), .greater(greater), .imm16(imm16), .imm26(imm26),
    .ra(ra), .pc(pc), .link(link), .redirected(redirected), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] op, input logic z, input logic s, input logic g,
                      input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] r);
    en = 1'b1; br_op = op; zero = z; smaller = s; greater = g;
    imm16 = i16; imm26 = i26; ra = r;
    @(posedge clk); #1;
  endtask

  task automatic seq();
    step(3'b000, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  // Stall with a taken jump presented, which must be ignored
  task automatic stall();
    en = 1'b0; br_op = 3'b101; imm26 = 26'h0C40;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_redir", {31'b0, redirected}, 32'h0);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    chk("rst_link", link, 32'h3000 + LOFF);

    seq(); chk("seq1_pc", pc, 32'h3004);
    seq(); chk("seq2_pc", pc, 32'h3008);
    seq(); chk("seq3_pc", pc, 32'h300C);
    chk("seq3_redir", {31'b0, redirected}, 32'h0);
    seq(); chk("seq4_pc", pc, 32'h3010);

    step(3'b001, 1'b1, 1'b0, 1'b0, 16'hFFFC, 26'h0, 32'h0);
`ifdef NPC_DELAY_SLOT_EN
    chk("beq_slot_pc", pc, 32'h3014);
    chk("beq_slot_redir", {31'b0, redirected}, 32'h0);
    seq();
`endif
    chk("beq_pc", pc, 32'h3004);
    chk("beq_redir", {31'b0, redirected}, 32'h1);
    seq();
    chk("after_beq_pc", pc, 32'h3008);
    chk("after_beq_redir", {31'b0, redirected}, 32'h0);

    do_reset();
    step(3'b010, 1'b1, 1'b0, 1'b0, 16'h0010, 26'h0, 32'h0);
    chk("bne_nt_pc", pc, 32'h3004);
    chk("bne_nt_redir", {31'b0, redirected}, 32'h0);
    stall(); chk("stall1_pc", pc, 32'h3004);
    stall(); chk("stall2_pc", pc, 32'h3004);
    chk("stall_redir", {31'b0, redirected}, 32'h0);
    step(3'b011, 1'b0, 1'b0, 1'b1, 16'h0010, 26'h0, 32'h0);
    chk("blt_nt_pc", pc, 32'h3008);

    step(3'b101, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0C40, 32'h0);
`ifdef NPC_DELAY_SLOT_EN
    chk("j_slot_pc", pc, 32'h300C);
    seq();
`endif
    chk("j_pc", pc, 32'h3100);
    chk("j_redir", {31'b0, redirected}, 32'h1);
    chk("j_link", link, 32'h3100 + LOFF);

    step(3'b110, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h3002);
`ifdef NPC_DELAY_SLOT_EN
    chk("jr_slot_pc", pc, 32'h3104);
    seq();
    chk("jr_mis_pc", pc, 32'h3104);
`else
    chk("jr_mis_pc", pc, 32'h3100);
`endif
    chk("jr_mis_halt", {31'b0, halt}, 32'h1);
    chk("jr_mis_redir", {31'b0, redirected}, 32'h0);
    step(3'b101, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0C40, 32'h0);
    seq();
`ifdef NPC_DELAY_SLOT_EN
    chk("halt_hold_pc", pc, 32'h3104);
`else
    chk("halt_hold_pc", pc, 32'h3100);
`endif
    chk("halt_sticky", {31'b0, halt}, 32'h1);
    do_reset();
    chk("halt_rst_pc", pc, 32'h3000);
    chk("halt_rst_halt", {31'b0, halt}, 32'h0);

    // Last legal word, then step off the end of the window
    step(3'b110, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h3FFC);
`ifdef NPC_DELAY_SLOT_EN
    seq();
`endif
    chk("last_word_pc", pc, 32'h3FFC);
    chk("last_word_halt", {31'b0, halt}, 32'h0);
    seq();
    chk("win_end_pc", pc, 32'h3FFC);
    chk("win_end_halt", {31'b0, halt}, 32'h1);

    do_reset();
    step(3'b101, 1'b0, 1'b0, 1'b0, 16'h0, 26'h1000, 32'h0);
`ifdef NPC_DELAY_SLOT_EN
    seq();
    chk("j_oob_pc", pc, 32'h3004);
`else
    chk("j_oob_pc", pc, 32'h3000);
`endif
    chk("j_oob_halt", {31'b0, halt}, 32'h1);

    do_reset();
    step(3'b110, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h2FFC);
`ifdef NPC_DELAY_SLOT_EN
    seq();
    chk("jr_low_pc", pc, 32'h3004);
`else
    chk("jr_low_pc", pc, 32'h3000);
`endif
    chk("jr_low_halt", {31'b0, halt}, 32'h1);

    do_reset();
    step(3'b111, 1'b1, 1'b1, 1'b1, 16'hFFFC, 26'h0C40, 32'h3100);
    chk("rsvd_pc", pc, 32'h3004);
    chk("rsvd_redir", {31'b0, redirected}, 32'h0);

`ifdef NPC_DELAY_SLOT_EN
    do_reset();
    step(3'b100, 1'b0, 1'b0, 1'b1, 16'h0004, 26'h0, 32'h0);
    chk("bgt_slot_pc", pc, 32'h3004);
    step(3'b011, 1'b0, 1'b1, 1'b0, 16'h0010, 26'h0, 32'h0);
    chk("bgt_tgt_pc", pc, 32'h3014);
    chk("bgt_tgt_redir", {31'b0, redirected}, 32'h1);
    seq();
    chk("bgt_after_pc", pc, 32'h3018);

    do_reset();
    step(3'b100, 1'b0, 1'b0, 1'b1, 16'h0004, 26'h0, 32'h0);
    stall();
    chk("pend_stall_pc", pc, 32'h3004);
    seq();
    chk("pend_stall_tgt", pc, 32'h3014);

    do_reset();
    step(3'b100, 1'b0, 1'b0, 1'b1, 16'h0004, 26'h0, 32'h0);
    do_reset();
    chk("slot_rst_pc", pc, 32'h3000);
    seq();
    chk("pend_clr_pc", pc, 32'h3004);
    chk("pend_clr_redir", {31'b0, redirected}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
